// File: rtl/nnet_vector_packetizer_if.sv
`default_nettype none
// ============================================================================
// Module   : nnet_vector_packetizer_if
// Purpose  : AXI-stream style bundle used for both the raw sample input and
//            the framed packet output of nnet_vector_packetizer.
// Ports    : tdata  - sample / payload word
//            tlast  - end of packet marker
//            tvalid - source has a word
//            tready - sink accepts the word
//            tuser  - sideband (packet header on the output side)
// Modports : master - drives the stream, slave - receives it
// Revision : 1.0 - initial release
// ============================================================================
interface nnet_vector_packetizer_if #(
  parameter int DATA_W = 32,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tvalid;
  logic              tready;
  logic [USER_W-1:0] tuser;

  modport master (output tdata, tlast, tvalid, tuser, input  tready);
  modport slave  (input  tdata, tlast, tvalid, tuser, output tready);
endinterface
`default_nettype wire

// File: rtl/nnet_vector_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : nnet_vector_packetizer
// Purpose  : Cuts a raw sample stream into fixed-size packets and produces the
//            128-bit CHDR header for each packet on the output tuser.
// Ports    : clk, reset (async, active-high), clear (sync)
//            src_sid, next_dst_sid - SIDs written into the header
//            pkt_size              - payload words per packet (latched at sof)
//            has_time              - include VITA time in the header
//            time_init, time_load  - load strobe for the VITA time counter
//            s_axis                - raw sample input (tlast/tuser ignored)
//            m_axis                - framed payload, header on tuser
//            seqnum_out            - sequence number of next packet to start
// Revision : 1.0 - initial release
// ============================================================================
module nnet_vector_packetizer #(
  parameter int WIDTH        = 16,
  parameter int PKT_SIZE_MAX = 2048
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clear,
  input  wire logic [15:0] src_sid,
  input  wire logic [15:0] next_dst_sid,
  input  wire logic [15:0] pkt_size,
  input  wire logic        has_time,
  input  wire logic [63:0] time_init,
  input  wire logic        time_load,
  nnet_vector_packetizer_if.slave  s_axis,
  nnet_vector_packetizer_if.master m_axis,
  output logic      [11:0] seqnum_out
);

  localparam logic [15:0] PSIZE_MAX_C = 16'(PKT_SIZE_MAX);

  logic [2*WIDTH-1:0] o_tdata_q, o_tdata_d;
  logic               o_tlast_q, o_tlast_d;
  logic               o_tvalid_q, o_tvalid_d;
  logic [127:0]       o_tuser_q, o_tuser_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [15:0]        psize_q, psize_d;
  logic               sof_q, sof_d;
  logic               ht_q, ht_d;
  logic [11:0]        seqnum_q, seqnum_d;
  logic [63:0]        time_q, time_d;

  logic               in_hs;
  logic               out_hs;
  logic [15:0]        psize_req;
  logic [15:0]        psize_cur;
  logic               ht_cur;
  logic               is_last;
  logic [15:0]        hdr_len;
  logic [127:0]       hdr_new;

  // Input tlast and tuser carry no framing meaning here.
  logic unused_ok;
  assign unused_ok = ^{1'b0, s_axis.tlast, s_axis.tuser};

  assign s_axis.tready = ~o_tvalid_q | m_axis.tready;
  assign in_hs         = s_axis.tvalid & s_axis.tready;
  assign out_hs        = o_tvalid_q & m_axis.tready;

  assign m_axis.tdata  = o_tdata_q;
  assign m_axis.tlast  = o_tlast_q;
  assign m_axis.tvalid = o_tvalid_q;
  assign m_axis.tuser  = o_tuser_q;
  assign seqnum_out    = seqnum_q;

  always_comb begin
    psize_req = pkt_size;
    if (pkt_size == 16'd0) begin
      psize_req = 16'd1;
    end else if (pkt_size > PSIZE_MAX_C) begin
      psize_req = PSIZE_MAX_C;
    end
  end

  // On the sof word the live inputs apply; afterwards the latched copies do,
  // so mid-packet changes only take effect on the next packet.
  assign psize_cur = sof_q ? psize_req : psize_q;
  assign ht_cur    = sof_q ? has_time  : ht_q;
  assign is_last   = (cnt_q == (psize_cur - 16'd1));

  // psize <= 2048 keeps 4*psize+16 well inside 16 bits.
  assign hdr_len = 16'(psize_req << 2) + 16'd8 + (has_time ? 16'd8 : 16'd0);
  assign hdr_new = {2'b00, has_time, 1'b0, seqnum_q, hdr_len, src_sid,
                    next_dst_sid, (has_time ? time_q : 64'd0)};

  always_comb begin
    o_tdata_d  = o_tdata_q;
    o_tlast_d  = o_tlast_q;
    o_tvalid_d = o_tvalid_q;
    o_tuser_d  = o_tuser_q;
    cnt_d      = cnt_q;
    psize_d    = psize_q;
    sof_d      = sof_q;
    ht_d       = ht_q;
    seqnum_d   = seqnum_q;
    time_d     = time_q;

    if (in_hs) begin
      o_tdata_d  = s_axis.tdata;
      o_tlast_d  = is_last;
      o_tvalid_d = 1'b1;
      if (sof_q) begin
        o_tuser_d = hdr_new;
        psize_d   = psize_req;
        ht_d      = has_time;
      end
      if (is_last) begin
        cnt_d    = 16'd0;
        sof_d    = 1'b1;
        seqnum_d = seqnum_q + 12'd1;
        if (ht_cur) begin
          time_d = time_q + 64'(psize_cur);
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
        sof_d = 1'b0;
      end
    end else if (out_hs) begin
      o_tvalid_d = 1'b0;
    end

    // A load replaces any increment in the same cycle.
    if (time_load) begin
      time_d = time_init;
    end

    if (clear) begin
      o_tdata_d  = '0;
      o_tlast_d  = 1'b0;
      o_tvalid_d = 1'b0;
      o_tuser_d  = '0;
      cnt_d      = 16'd0;
      psize_d    = 16'd1;
      sof_d      = 1'b1;
      ht_d       = 1'b0;
      seqnum_d   = 12'd0;
      time_d     = 64'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_tdata_q  <= '0;
      o_tlast_q  <= 1'b0;
      o_tvalid_q <= 1'b0;
      o_tuser_q  <= '0;
      cnt_q      <= 16'd0;
      psize_q    <= 16'd1;
      sof_q      <= 1'b1;
      ht_q       <= 1'b0;
      seqnum_q   <= 12'd0;
      time_q     <= 64'd0;
    end else begin
      o_tdata_q  <= o_tdata_d;
      o_tlast_q  <= o_tlast_d;
      o_tvalid_q <= o_tvalid_d;
      o_tuser_q  <= o_tuser_d;
      cnt_q      <= cnt_d;
      psize_q    <= psize_d;
      sof_q      <= sof_d;
      ht_q       <= ht_d;
      seqnum_q   <= seqnum_d;
      time_q     <= time_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/nnet_vector_packetizer.md
Name: nnet_vector_packetizer

Overview:
Transmit-side framer for neural-net vector output streams.
- Takes a raw sample stream from user code and cuts it into fixed-size packets.
- Generates the 128-bit CHDR header on o_tuser for each packet: seqnum, byte length, SIDs, optional VITA time.
- Sits between an HLS core's output and the axi_wrapper's m_axis input, for blocks that do not carry an input header forward.

Parameters:
WIDTH, 16, half data width; data bus is 2*WIDTH bits (one complex/packed sample per beat)
PKT_SIZE_MAX, 2048, maximum payload words per packet; larger pkt_size values are clamped to this

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous clear; same effect as reset, sampled on clk
src_sid  in  16  source SID written to header
next_dst_sid  in  16  destination SID written to header
pkt_size  in  16  payload words per packet
has_time  in  1  include VITA time in header
time_init  in  64  value loaded into time counter
time_load  in  1  single-cycle strobe: load time counter from time_init
i_tdata  in  2*WIDTH  user sample data
i_tlast  in  1  ignored for framing
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  2*WIDTH  packet payload
o_tlast  out  1  last word of packet
o_tvalid  out  1  output valid
o_tready  in  1  output ready
o_tuser  out  128  header for current packet
seqnum_out  out  12  sequence number of the next packet to be started (status)

Behaviour:
- Reset/clear values: o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, seqnum=0, word count=0, time counter=0, sof=1.
- Output stage: single register stage, 1-cycle latency.
  - i_tready = ~o_tvalid | o_tready, combinational; it is 1 out of reset.
  - On an input handshake, data/tlast/tuser load into the output register and o_tvalid goes to 1.
  - o_tvalid drops only on an output handshake with no simultaneous input handshake.
  - Output holds stable while o_tvalid & ~o_tready.
- Packet size latch:
  - On the first accepted word of a packet (sof=1), psize is latched from pkt_size.
  - 0 is treated as 1; values above PKT_SIZE_MAX are treated as PKT_SIZE_MAX.
  - Changes to pkt_size mid-packet have no effect until the next packet.
- Word counter: increments per input handshake.
  - o_tlast is registered as 1 when count == psize-1; the counter then returns to 0 and sof becomes 1.
  - Packets are always exactly psize words; i_tlast has no effect.
- Header: computed on the sof word and held in o_tuser, unchanged for every word of the packet.
  - Format: o_tuser = {pkt_type=2'b00, has_time, eob=1'b0, seqnum[11:0], length[15:0], src_sid, next_dst_sid, vita_time[63:0]}.
  - length = 4*psize + 8 + (has_time ? 8 : 0) bytes, computed 16-bit, with no overflow at PKT_SIZE_MAX.
  - vita_time = time counter when has_time=1, else 0.
  - has_time, src_sid and next_dst_sid are latched at sof.
- Seqnum: increments by 1 on the input handshake of each tlast word; wraps 4095 -> 0.
- Time counter:
  - Increments by psize on each tlast-word handshake when has_time was latched as 1.
  - time_load overrides the increment in the same cycle; the load affects only packets whose sof occurs after it.
  - 64-bit counter wraps naturally.
- Mid-packet reset/clear: the partial packet is discarded, with no tlast emitted; the next accepted word starts a fresh packet with seqnum 0.
- Sustained throughput is 1 word/cycle with o_tready held high; there are no bubbles between packets.

Test Plan:
- pkt_size=4, has_time=0, 12 words streamed continuously, o_tready=1 -> 3 packets; tlast on words 4, 8 and 12; seqnum 0, 1, 2; length=24; vita_time=0; no idle cycles.
- pkt_size=3, has_time=1, time_load with time_init=0x100, 2 packets -> vita_time 0x100 then 0x103; length=28.
- Random o_tready/i_tvalid throttling over 1000 words, pkt_size=7 -> output data equals input order, o_tuser constant within each packet, o_tdata/o_tuser held while stalled.
- pkt_size changed 4 -> 8 after the first word of a packet -> that packet ends at 4 words; the next packet has 8 words.
- 4097 packets with pkt_size=1 -> seqnum wraps 4095 -> 0; pkt_size=0 behaves as 1; pkt_size=65535 gives length=8200 (clamped to 2048 words).
- Assert reset after 2 of 4 words -> o_tvalid=0 immediately (asynchronous); next packet has seqnum 0, 4 full words and tlast on the 4th.
